// File: rtl/aes_decipher_block_par_if.sv
// Bus between the AES core control / key memory and the iterative
// inverse-cipher datapath.
//
// Handshake: 'next' is a start request that is accepted only while
// ready=1 (idle) and abort=0; requests while ready=0 are dropped, never
// queued. ready=1 means the datapath is idle and new_block holds a valid
// result. 'done' pulses for exactly one cycle when a result completes;
// aborted or reset operations give no pulse. round/round_key is a
// same-cycle request/response: the key memory answers 'round' with
// 'round_key' combinationally. fsm_state exposes the FSM for observation.
interface aes_decipher_block_par_if;
    logic         next;
    logic         abort;
    logic [1:0]   keylen;
    logic [3:0]   round;
    logic [127:0] round_key;
    logic [127:0] block;
    logic [127:0] new_block;
    logic         ready;
    logic         done;
    logic [1:0]   fsm_state;

    modport master (
        output next, abort, keylen, round_key, block,
        input  round, new_block, ready, done, fsm_state
    );

    modport slave (
        input  next, abort, keylen, round_key, block,
        output round, new_block, ready, done, fsm_state
    );
endinterface

// File: rtl/aes_decipher_block_par.sv
// Iterative AES inverse cipher with SBOX_LANES 32-bit InvSubBytes words
// per cycle, AES-128/192/256, synchronous abort and a done pulse.
// Each round is GROUPS = 4/SBOX_LANES substitution cycles followed by one
// key-add / InvMixColumns / InvShiftRows cycle.
module aes_decipher_block_par #(
    parameter int SBOX_LANES = 4,
    parameter bit EN_192     = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    aes_decipher_block_par_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_INIT = 2'd1,
        ST_SBOX = 2'd2,
        ST_MAIN = 2'd3
    } state_t;

    localparam int         GROUPS     = 4 / SBOX_LANES;
    localparam logic [1:0] LAST_GROUP = 2'(GROUPS - 1);
    // Word stride between groups; for 4 lanes there is a single group.
    localparam logic [1:0] LANE_STEP  = 2'(SBOX_LANES);

    if (!(SBOX_LANES == 1 || SBOX_LANES == 2 || SBOX_LANES == 4)) begin : g_bad_lanes
        $error("aes_decipher_block_par: SBOX_LANES must be 1, 2 or 4");
    end

    // Inverse S-box, entry b at bits [8*(255-b)+7 -: 8].
    localparam logic [2047:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return INV_SBOX[{~b, 3'b111} -: 8];
    endfunction

    function automatic logic [31:0] inv_sub_word(input logic [31:0] w);
        return {inv_sbox(w[31:24]), inv_sbox(w[23:16]),
                inv_sbox(w[15:8]),  inv_sbox(w[7:0])};
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] mul9(input logic [7:0] b);
        return xt(xt(xt(b))) ^ b;
    endfunction

    function automatic logic [7:0] mulb(input logic [7:0] b);
        return xt(xt(xt(b))) ^ xt(b) ^ b;
    endfunction

    function automatic logic [7:0] muld(input logic [7:0] b);
        return xt(xt(xt(b))) ^ xt(xt(b)) ^ b;
    endfunction

    function automatic logic [7:0] mule(input logic [7:0] b);
        return xt(xt(xt(b))) ^ xt(xt(b)) ^ xt(b);
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] w);
        logic [7:0] a0, a1, a2, a3;
        a0 = w[31:24];
        a1 = w[23:16];
        a2 = w[15:8];
        a3 = w[7:0];
        return {mule(a0) ^ mulb(a1) ^ muld(a2) ^ mul9(a3),
                mul9(a0) ^ mule(a1) ^ mulb(a2) ^ muld(a3),
                muld(a0) ^ mul9(a1) ^ mule(a2) ^ mulb(a3),
                mulb(a0) ^ muld(a1) ^ mul9(a2) ^ mule(a3)};
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        return {inv_mix_col(s[127:96]), inv_mix_col(s[95:64]),
                inv_mix_col(s[63:32]),  inv_mix_col(s[31:0])};
    endfunction

    // Byte (row r, column c) sits at index 4c+r, byte 0 in [127:120].
    // Row r is rotated right by r columns.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c - r + 4) % 4) + r) -: 8];
            end
        end
        return o;
    endfunction

    state_t       fsm;
    logic [127:0] work;
    logic [3:0]   round_q;
    logic         ready_q;
    logic         done_q;
    logic [1:0]   sword_ctr;

    logic [3:0]   nr_start;
    logic [31:0]  st_words  [4];
    logic [31:0]  sub_words [4];
    logic [127:0] sub_work;
    logic [127:0] init_work;
    logic [127:0] round_work;
    logic [127:0] final_work;

    // Number of rounds for the key length presented at start.
    always_comb begin
        nr_start = 4'd10;
        case (bus.keylen)
            2'b00:   nr_start = 4'd10;
            2'b01:   nr_start = EN_192 ? 4'd12 : 4'd10;
            default: nr_start = 4'd14;
        endcase
    end

    // InvSubBytes on the word group selected by sword_ctr; other words pass.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            st_words[k] = work[127 - 32*k -: 32];
        end
        sub_words = st_words;
        for (int j = 0; j < SBOX_LANES; j++) begin
            sub_words[sword_ctr * LANE_STEP + 2'(j)] =
                inv_sub_word(st_words[sword_ctr * LANE_STEP + 2'(j)]);
        end
        sub_work = {sub_words[0], sub_words[1], sub_words[2], sub_words[3]};
    end

    // Round transforms that use the key presented for the current round.
    always_comb begin
        init_work  = inv_shift_rows(bus.block ^ bus.round_key);
        round_work = inv_shift_rows(inv_mix_columns(work ^ bus.round_key));
        final_work = work ^ bus.round_key;
    end

    // Control FSM with registered outputs; abort wins over every other action.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fsm       <= ST_IDLE;
            work      <= '0;
            round_q   <= '0;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
            sword_ctr <= '0;
        end else begin
            done_q <= 1'b0;
            if (fsm == ST_IDLE) begin
                if (bus.next && !bus.abort) begin
                    round_q <= nr_start;
                    ready_q <= 1'b0;
                    fsm     <= ST_INIT;
                end
            end else if (bus.abort) begin
                fsm       <= ST_IDLE;
                work      <= '0;
                round_q   <= '0;
                ready_q   <= 1'b1;
                sword_ctr <= '0;
            end else begin
                case (fsm)
                    ST_INIT: begin
                        work      <= init_work;
                        sword_ctr <= '0;
                        fsm       <= ST_SBOX;
                    end
                    ST_SBOX: begin
                        work <= sub_work;
                        if (sword_ctr == LAST_GROUP) begin
                            sword_ctr <= '0;
                            if (round_q != 4'd0) begin
                                round_q <= round_q - 4'd1;
                            end
                            fsm <= ST_MAIN;
                        end else begin
                            sword_ctr <= sword_ctr + 2'd1;
                        end
                    end
                    ST_MAIN: begin
                        if (round_q != 4'd0) begin
                            work <= round_work;
                            fsm  <= ST_SBOX;
                        end else begin
                            work    <= final_work;
                            ready_q <= 1'b1;
                            done_q  <= 1'b1;
                            fsm     <= ST_IDLE;
                        end
                    end
                    default: fsm <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.round     = round_q;
    assign bus.new_block = work;
    assign bus.ready     = ready_q;
    assign bus.done      = done_q;
    assign bus.fsm_state = fsm;

endmodule

// File: tb/tb_aes_decipher_block_par.sv
// Bench for aes_decipher_block_par: three instances (4, 2 and 1 S-box
// lanes) share one key memory and stimulus. Expected plaintexts come from
// a forward AES cipher model with a computed S-box; ciphertexts are either
// the FIPS-197 vectors or model encryptions of random plaintexts.
module tb_aes_decipher_block_par;

    localparam int NDUT = 3;

    logic         clk     = 1'b0;
    logic         reset_n = 1'b0;
    logic [2:0]   next_v  = '0;
    logic         abort   = 1'b0;
    logic [1:0]   keylen  = 2'b00;
    logic [127:0] block   = '0;

    logic [127:0] rk [0:15];
    logic [7:0]   sb [256];

    int n_asserts = 0;
    int n_fail    = 0;

    always #5 clk = ~clk;

    aes_decipher_block_par_if bus4 ();
    aes_decipher_block_par_if bus2 ();
    aes_decipher_block_par_if bus1 ();

    aes_decipher_block_par #(.SBOX_LANES(4), .EN_192(1'b1)) dut4 (.clk(clk), .reset_n(reset_n), .bus(bus4));
    aes_decipher_block_par #(.SBOX_LANES(2), .EN_192(1'b1)) dut2 (.clk(clk), .reset_n(reset_n), .bus(bus2));
    aes_decipher_block_par #(.SBOX_LANES(1), .EN_192(1'b1)) dut1 (.clk(clk), .reset_n(reset_n), .bus(bus1));

    assign bus4.next = next_v[0];
    assign bus2.next = next_v[1];
    assign bus1.next = next_v[2];
    assign bus4.abort = abort;
    assign bus2.abort = abort;
    assign bus1.abort = abort;
    assign bus4.keylen = keylen;
    assign bus2.keylen = keylen;
    assign bus1.keylen = keylen;
    assign bus4.block = block;
    assign bus2.block = block;
    assign bus1.block = block;
    // Key memory: answers each instance's round request in the same cycle.
    assign bus4.round_key = rk[bus4.round];
    assign bus2.round_key = rk[bus2.round];
    assign bus1.round_key = rk[bus1.round];

    logic [127:0] nb  [NDUT];
    logic [3:0]   rnd [NDUT];
    logic         rdy [NDUT];
    logic         dn  [NDUT];
    assign nb[0] = bus4.new_block;
    assign nb[1] = bus2.new_block;
    assign nb[2] = bus1.new_block;
    assign rnd[0] = bus4.round;
    assign rnd[1] = bus2.round;
    assign rnd[2] = bus1.round;
    assign rdy[0] = bus4.ready;
    assign rdy[1] = bus2.ready;
    assign rdy[2] = bus1.ready;
    assign dn[0] = bus4.done;
    assign dn[1] = bus2.done;
    assign dn[2] = bus1.done;

    function automatic int lanes(input int i);
        return (i == 0) ? 4 : ((i == 1) ? 2 : 1);
    endfunction

    function automatic int exp_latency(input int i, input int nr);
        return 2 + nr * (4 / lanes(i) + 1);
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // GF(2^8) multiply, AES polynomial.
    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in;
        b = b_in;
        p = 8'h00;
        for (int k = 0; k < 8; k++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    // S-box from its definition: multiplicative inverse then affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
    endfunction

    // Key schedule into rk[0..Nr]; key is left-aligned in 256 bits.
    task automatic expand(input logic [255:0] key, input int nk);
        logic [31:0] w [60];
        logic [31:0] temp;
        logic [7:0]  rc;
        int nr;
        nr = nk + 6;
        rc = 8'h01;
        for (int i = 0; i < 60; i++) w[i] = '0;
        for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
        for (int i = nk; i < 4 * (nr + 1); i++) begin
            temp = w[i-1];
            if (i % nk == 0) begin
                temp = sub_word({temp[23:0], temp[31:24]}) ^ {rc, 24'h000000};
                rc = gmul(rc, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                temp = sub_word(temp);
            end
            w[i] = w[i-nk] ^ temp;
        end
        for (int r = 0; r < 16; r++) rk[r] = '0;
        for (int r = 0; r <= nr; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // Forward cipher on a byte array; byte i = bits [127-8i -: 8], row i%4, column i/4.
    function automatic logic [127:0] encrypt(input logic [127:0] pt, input int nr);
        logic [7:0] s [16];
        logic [7:0] t [16];
        logic [127:0] o;
        for (int i = 0; i < 16; i++) s[i] = pt[127 - 8*i -: 8] ^ rk[0][127 - 8*i -: 8];
        for (int r = 1; r <= nr; r++) begin
            for (int i = 0; i < 16; i++) s[i] = sb[s[i]];
            for (int c = 0; c < 4; c++)
                for (int q = 0; q < 4; q++)
                    t[4*c + q] = s[4*((c + q) % 4) + q];
            if (r < nr) begin
                for (int c = 0; c < 4; c++) begin
                    s[4*c]   = gmul(8'h02, t[4*c]) ^ gmul(8'h03, t[4*c+1]) ^ t[4*c+2] ^ t[4*c+3];
                    s[4*c+1] = t[4*c] ^ gmul(8'h02, t[4*c+1]) ^ gmul(8'h03, t[4*c+2]) ^ t[4*c+3];
                    s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(8'h02, t[4*c+2]) ^ gmul(8'h03, t[4*c+3]);
                    s[4*c+3] = gmul(8'h03, t[4*c]) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(8'h02, t[4*c+3]);
                end
            end else begin
                s = t;
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk[r][127 - 8*i -: 8];
        end
        o = '0;
        for (int i = 0; i < 16; i++) o[127 - 8*i -: 8] = s[i];
        return o;
    endfunction

    // Starts all instances together and follows each to completion.
    // hammer: keep next high while busy; b2b: restart on the done cycle;
    // scramble: change keylen mid-operation.
    task automatic run_ops(input string tag, input logic [127:0] ct, input logic [127:0] pt,
                           input int nr, input bit hammer, input bit b2b, input bit scramble);
        int  ops_need;
        int  ops_done [NDUT];
        int  start    [NDUT];
        int  done_cnt [NDUT];
        bit  busy     [NDUT];
        int  cyc;
        bit  all_done;
        ops_need = b2b ? 2 : 1;
        for (int i = 0; i < NDUT; i++) begin
            ops_done[i] = 0;
            start[i]    = 0;
            done_cnt[i] = 0;
            busy[i]     = 1'b0;
        end
        cyc      = 0;
        all_done = 1'b0;
        block    = ct;
        next_v   = 3'b111;
        while (!all_done && cyc < 600) begin
            @(posedge clk);
            #1;
            cyc++;
            for (int i = 0; i < NDUT; i++) begin
                if (dn[i] === 1'b1) done_cnt[i]++;
                if (rdy[i] === 1'b0) begin
                    busy[i] = 1'b1;
                end else if (busy[i] && ops_done[i] < ops_need) begin
                    chk($sformatf("%s L%0d result", tag, lanes(i)), nb[i], pt);
                    chk($sformatf("%s L%0d latency", tag, lanes(i)), 128'(cyc - start[i]),
                        128'(exp_latency(i, nr)));
                    chk($sformatf("%s L%0d done with ready", tag, lanes(i)), 128'(dn[i]), 128'(1));
                    ops_done[i]++;
                    busy[i]  = 1'b0;
                    start[i] = cyc;
                end
            end
            for (int i = 0; i < NDUT; i++) begin
                next_v[i] = 1'b0;
                if (hammer && busy[i]) next_v[i] = 1'b1;
                if (b2b && ops_done[i] == 1 && start[i] == cyc) next_v[i] = 1'b1;
            end
            if (scramble && cyc == 3) keylen = 2'($urandom_range(0, 3));
            all_done = 1'b1;
            for (int i = 0; i < NDUT; i++) if (ops_done[i] != ops_need) all_done = 1'b0;
        end
        next_v = '0;
        chk($sformatf("%s completed within budget", tag), 128'(all_done), 128'(1));
        repeat (2) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < NDUT; i++) if (dn[i] === 1'b1) done_cnt[i]++;
        end
        for (int i = 0; i < NDUT; i++)
            chk($sformatf("%s L%0d done pulses", tag, lanes(i)), 128'(done_cnt[i]), 128'(ops_need));
    endtask

    task automatic chk_reset_values(input string tag);
        for (int i = 0; i < NDUT; i++) begin
            chk($sformatf("%s L%0d new_block", tag, lanes(i)), nb[i], 128'h0);
            chk($sformatf("%s L%0d round", tag, lanes(i)), 128'(rnd[i]), 128'(0));
            chk($sformatf("%s L%0d ready", tag, lanes(i)), 128'(rdy[i]), 128'(1));
            chk($sformatf("%s L%0d done", tag, lanes(i)), 128'(dn[i]), 128'(0));
        end
    endtask

    localparam logic [255:0] KEY_FIPS = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] PT_FIPS  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_128   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT_192   = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] CT_256   = 128'h8ea2b7ca516745bfeafc49904b496089;

    initial begin
        logic [255:0] key;
        logic [127:0] pt;
        logic [127:0] ct;
        int           kl;
        int           nk;
        int           stray_done;

        for (int r = 0; r < 16; r++) rk[r] = '0;
        build_sbox();

        // Reset state, then release away from the clock edge.
        repeat (3) @(posedge clk);
        #1;
        chk_reset_values("reset");
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Model agrees with the published encryption vectors.
        expand(KEY_FIPS, 6);
        chk("model C.2", encrypt(PT_FIPS, 12), CT_192);
        expand(KEY_FIPS, 8);
        chk("model C.3", encrypt(PT_FIPS, 14), CT_256);
        expand(KEY_FIPS, 4);
        chk("model C.1", encrypt(PT_FIPS, 10), CT_128);

        // FIPS-197 decryptions for every key length encoding.
        keylen = 2'b00;
        run_ops("C.1", CT_128, PT_FIPS, 10, 1'b0, 1'b0, 1'b0);
        expand(KEY_FIPS, 6);
        keylen = 2'b01;
        run_ops("C.2", CT_192, PT_FIPS, 12, 1'b0, 1'b0, 1'b0);
        expand(KEY_FIPS, 8);
        keylen = 2'b10;
        run_ops("C.3 kl10", CT_256, PT_FIPS, 14, 1'b0, 1'b0, 1'b0);
        keylen = 2'b11;
        run_ops("C.3 kl11", CT_256, PT_FIPS, 14, 1'b0, 1'b0, 1'b0);

        // Abort at cycle 20 of a C.1 decipher, then immediate restart.
        expand(KEY_FIPS, 4);
        keylen = 2'b00;
        block  = CT_128;
        next_v = 3'b111;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            #1;
            next_v = '0;
        end
        for (int i = 0; i < NDUT; i++)
            chk($sformatf("busy before abort L%0d", lanes(i)), 128'(rdy[i]), 128'(0));
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        chk_reset_values("after abort");
        stray_done = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < NDUT; i++) if (dn[i] !== 1'b0) stray_done++;
        end
        chk("no done after abort", 128'(stray_done), 128'(0));
        run_ops("restart after abort", CT_128, PT_FIPS, 10, 1'b0, 1'b0, 1'b0);

        // Abort beats next in IDLE; abort alone in IDLE changes nothing.
        abort  = 1'b1;
        next_v = 3'b111;
        @(posedge clk);
        #1;
        next_v = '0;
        @(posedge clk);
        #1;
        abort = 1'b0;
        for (int i = 0; i < NDUT; i++) begin
            chk($sformatf("idle abort L%0d ready", lanes(i)), 128'(rdy[i]), 128'(1));
            chk($sformatf("idle abort L%0d holds result", lanes(i)), nb[i], PT_FIPS);
        end

        // next held during operation with keylen changing mid-run.
        keylen = 2'b00;
        run_ops("next hammer", CT_128, PT_FIPS, 10, 1'b1, 1'b0, 1'b1);
        keylen = 2'b00;

        // Second start issued on the done cycle.
        run_ops("back to back", CT_128, PT_FIPS, 10, 1'b0, 1'b1, 1'b0);

        // Asynchronous reset in the middle of a run.
        block  = CT_128;
        next_v = 3'b111;
        @(posedge clk);
        #1;
        next_v = '0;
        repeat (9) @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        chk_reset_values("async reset");
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        run_ops("C.1 after reset", CT_128, PT_FIPS, 10, 1'b0, 1'b0, 1'b0);

        // Random keys of random length against the forward model.
        for (int n = 0; n < 6; n++) begin
            kl  = $urandom_range(0, 3);
            nk  = (kl == 0) ? 4 : ((kl == 1) ? 6 : 8);
            key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            pt  = {$urandom, $urandom, $urandom, $urandom};
            expand(key, nk);
            ct  = encrypt(pt, nk + 6);
            keylen = 2'(kl);
            run_ops($sformatf("random %0d kl%0d", n, kl), ct, pt, nk + 6, 1'b0, 1'b0, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
